// File: rtl/atm_pkg.sv
// atm_pkg
//   Shared definitions for the ATM user-input path.
//   - state_t   : entry collector states (COLLECT, COMPLETE)
//   - DIGIT_MAX : largest legal decimal digit from the converter
//   - PIN_LEN / ACC_LEN : entry lengths the control FSM drives onto
//                         expected_len for a PIN or an account number
package atm_pkg;

  typedef enum logic {
    COLLECT  = 1'b0,
    COMPLETE = 1'b1
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] PIN_LEN   = 4'd4;
  localparam logic [3:0] ACC_LEN   = 4'd8;

endpackage

// File: rtl/digit_entry_collector.sv
// digit_entry_collector
//   Packs the binary digits coming out of the ASCII-to-binary converter
//   into a BCD entry register (newest digit in the low nibble). Supports
//   backspace, clear (quit key) and a length check on enter. A valid entry
//   is frozen and flagged with a level-held 'complete' until acknowledged.
//
// Ports
//   clk          in   system clock, posedge
//   rst          in   synchronous active-high reset
//   digit_valid  in   strobe, 'digit' valid this cycle
//   digit        in   binary digit 0..9
//   enter        in   strobe, entry finished
//   backspace    in   strobe, drop the newest digit
//   clear        in   strobe, discard the entry
//   expected_len in   required digit count, sampled on enter
//   ack          in   consumer accepted the completed entry
//   value        out  packed BCD entry, unused upper nibbles are 0
//   count        out  digits currently held
//   complete     out  level, entry valid and frozen
//   error        out  one-cycle pulse on a rejected action
module digit_entry_collector
  import atm_pkg::*;
#(
  parameter int MAX_DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      digit_valid,
  input  logic [3:0]                digit,
  input  logic                      enter,
  input  logic                      backspace,
  input  logic                      clear,
  input  logic [3:0]                expected_len,
  input  logic                      ack,
  output logic [4*MAX_DIGITS-1:0]   value,
  output logic [3:0]                count,
  output logic                      complete,
  output logic                      error
);

  localparam int         ValueW   = 4 * MAX_DIGITS;
  localparam logic [3:0] MaxCount = 4'(MAX_DIGITS);

  state_t            state_q;
  logic [ValueW-1:0] value_q;
  logic [3:0]        count_q;
  logic              complete_q;
  logic              error_q;

  // An enter is only accepted when the typed length matches the requested
  // one and that request is itself a length the register can hold; a zero
  // length request is therefore always rejected.
  logic lenOk;
  assign lenOk = (count_q == expected_len) &&
                 (expected_len >= 4'd1) &&
                 (expected_len <= MaxCount);

  // Whole collector FSM with registered outputs. error defaults low every
  // cycle so each rejected action yields exactly one pulse, and consecutive
  // rejects give consecutive pulses. In COLLECT only the highest-priority
  // strobe acts: clear, then enter, then backspace, then digit_valid.
  // In COMPLETE the entry is frozen; only ack or clear release it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      value_q    <= '0;
      count_q    <= '0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (clear) begin
            value_q <= '0;
            count_q <= '0;
          end else if (enter) begin
            if (lenOk) begin
              state_q    <= COMPLETE;
              complete_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
              value_q <= '0;
              count_q <= '0;
            end
          end else if (backspace) begin
            if (count_q != 4'd0) begin
              value_q <= value_q >> 4;
              count_q <= count_q - 4'd1;
            end
          end else if (digit_valid) begin
            if (digit > DIGIT_MAX || count_q == MaxCount) begin
              error_q <= 1'b1;
            end else begin
              value_q <= {value_q[ValueW-5:0], digit};
              count_q <= count_q + 4'd1;
            end
          end
        end
        COMPLETE: begin
          if (ack || clear) begin
            state_q    <= COLLECT;
            value_q    <= '0;
            count_q    <= '0;
            complete_q <= 1'b0;
          end
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign value    = value_q;
  assign count    = count_q;
  assign complete = complete_q;
  assign error    = error_q;

endmodule

// File: tb/tb_digit_entry_collector.sv
// tb_digit_entry_collector
//   Directed self-checking bench for digit_entry_collector (MAX_DIGITS = 8).
module tb_digit_entry_collector;
  import atm_pkg::*;

  logic        clk;
  logic        rst;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        enter;
  logic        backspace;
  logic        clear;
  logic [3:0]  expected_len;
  logic        ack;
  logic [31:0] value;
  logic [3:0]  count;
  logic        complete;
  logic        error;

  int checks   = 0;
  int failures = 0;

  digit_entry_collector #(.MAX_DIGITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .enter        (enter),
    .backspace    (backspace),
    .clear        (clear),
    .expected_len (expected_len),
    .ack          (ack),
    .value        (value),
    .count        (count),
    .complete     (complete),
    .error        (error)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, required finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  // Drive one cycle of inputs, let the edge capture them, then return the
  // strobes to idle 1 time unit after the edge where outputs are sampled.
  task automatic applyStimulus(input logic dv, input logic [3:0] d,
                               input logic en, input logic bs,
                               input logic clr, input logic ak,
                               input logic [3:0] el, input logic rs);
    digit_valid  = dv;
    digit        = d;
    enter        = en;
    backspace    = bs;
    clear        = clr;
    ack          = ak;
    expected_len = el;
    rst          = rs;
    @(posedge clk);
    #1;
    digit_valid  = 1'b0;
    digit        = 4'd0;
    enter        = 1'b0;
    backspace    = 1'b0;
    clear        = 1'b0;
    ack          = 1'b0;
    expected_len = 4'd0;
    rst          = 1'b0;
  endtask

  task automatic pushDigit(input logic [3:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // Compare all four outputs against hand-computed expectations.
  task automatic checkOutput(input string tag, input logic [31:0] expValue,
                             input logic [3:0] expCount,
                             input logic expComplete, input logic expError);
    checks++;
    assert (value === expValue) else begin
      failures++;
      $error("[TB] FAIL %s.value observed=%h expected=%h", tag, value, expValue);
    end
    checks++;
    assert (count === expCount) else begin
      failures++;
      $error("[TB] FAIL %s.count observed=%0d expected=%0d", tag, count, expCount);
    end
    checks++;
    assert (complete === expComplete) else begin
      failures++;
      $error("[TB] FAIL %s.complete observed=%b expected=%b", tag, complete, expComplete);
    end
    checks++;
    assert (error === expError) else begin
      failures++;
      $error("[TB] FAIL %s.error observed=%b expected=%b", tag, error, expError);
    end
  endtask

  initial begin
    digit_valid  = 1'b0;
    digit        = 4'd0;
    enter        = 1'b0;
    backspace    = 1'b0;
    clear        = 1'b0;
    ack          = 1'b0;
    expected_len = 4'd0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset", 32'h0, 4'd0, 1'b0, 1'b0);

    // PIN accept, then freeze, then ack
    pushDigit(4'd1);
    checkOutput("pin_d1", 32'h1, 4'd1, 1'b0, 1'b0);
    pushDigit(4'd2);
    pushDigit(4'd3);
    pushDigit(4'd4);
    checkOutput("pin_d4", 32'h1234, 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, PIN_LEN, 1'b0);
    checkOutput("pin_enter", 32'h1234, 4'd4, 1'b1, 1'b0);
    idle();
    checkOutput("pin_hold", 32'h1234, 4'd4, 1'b1, 1'b0);
    pushDigit(4'd7);
    checkOutput("complete_digit_ignored", 32'h1234, 4'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
    checkOutput("complete_enter_bs_ignored", 32'h1234, 4'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    checkOutput("pin_ack", 32'h0, 4'd0, 1'b0, 1'b0);

    // ack in COLLECT is ignored
    pushDigit(4'd7);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    checkOutput("collect_ack_ignored", 32'h7, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("collect_clear", 32'h0, 4'd0, 1'b0, 1'b0);

    // Backspace
    pushDigit(4'd5);
    pushDigit(4'd6);
    pushDigit(4'd7);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("bs_pop", 32'h56, 4'd2, 1'b0, 1'b0);
    pushDigit(4'd8);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
    checkOutput("bs_enter", 32'h568, 4'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("complete_clear", 32'h0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("bs_empty", 32'h0, 4'd0, 1'b0, 1'b0);

    // Backspace outranks digit_valid
    pushDigit(4'd3);
    pushDigit(4'd9);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("bs_over_digit", 32'h3, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

    // Wrong length
    pushDigit(4'd9);
    pushDigit(4'd9);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, PIN_LEN, 1'b0);
    checkOutput("wrong_len", 32'h0, 4'd0, 1'b0, 1'b1);
    idle();
    checkOutput("wrong_len_after", 32'h0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("zero_len_enter", 32'h0, 4'd0, 1'b0, 1'b1);

    // Overflow and illegal digit; back-to-back error pulses
    for (int i = 1; i <= 8; i++) pushDigit(4'(i));
    checkOutput("fill8", 32'h12345678, 4'd8, 1'b0, 1'b0);
    pushDigit(4'd9);
    checkOutput("overflow", 32'h12345678, 4'd8, 1'b0, 1'b1);
    pushDigit(4'hA);
    checkOutput("illegal_digit", 32'h12345678, 4'd8, 1'b0, 1'b1);
    idle();
    checkOutput("err_drop", 32'h12345678, 4'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, ACC_LEN, 1'b0);
    checkOutput("acc_enter", 32'h12345678, 4'd8, 1'b1, 1'b0);

    // Reset in COMPLETE overrides a simultaneous ack-free strobe
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("rst_complete", 32'h0, 4'd0, 1'b0, 1'b0);

    // Illegal digit with an empty register
    pushDigit(4'hF);
    checkOutput("illegal_empty", 32'h0, 4'd0, 1'b0, 1'b1);

    // Priority: clear beats enter and digit_valid
    pushDigit(4'd1);
    pushDigit(4'd2);
    pushDigit(4'd3);
    applyStimulus(1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
    checkOutput("clear_priority", 32'h0, 4'd0, 1'b0, 1'b0);

    // Priority: enter beats backspace
    pushDigit(4'd1);
    pushDigit(4'd2);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
    checkOutput("enter_over_bs", 32'h12, 4'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);

    // Reset mid-entry
    pushDigit(4'd4);
    pushDigit(4'd2);
    checkOutput("pre_rst", 32'h42, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("rst_mid", 32'h0, 4'd0, 1'b0, 1'b0);
    pushDigit(4'd6);
    checkOutput("after_rst", 32'h6, 4'd1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
